// File: rtl/spi_pkg.sv
// Lane-mode constants and mode-to-step decode shared by the SPI frame collector.
package spi_pkg;

    localparam logic [1:0] MODE_1B   = 2'b00;
    localparam logic [1:0] MODE_2B   = 2'b01;
    localparam logic [1:0] MODE_4B   = 2'b11;
    localparam logic [1:0] MODE_IDLE = 2'b10;

    function automatic logic [2:0] mode_step(input logic [1:0] mode);
        case (mode)
            MODE_1B: return 3'd1;
            MODE_2B: return 3'd2;
            MODE_4B: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/spi_frame_fifo.sv
// Frame FIFO: power-of-2 depth, wrapping pointers, unreset storage, occupancy count.
module spi_frame_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // A push into a full FIFO is only taken when the head leaves on the same edge.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/spi_frame_collector.sv
// Counts shifted bits of an upstream SPI shift register and queues each completed frame.
// Optional dropped-frame counter enabled by defining SPI_FRAME_OVF_CNT_EN.
module spi_frame_collector
    import spi_pkg::*;
#(
    parameter int   REGSIZE    = 8,
    parameter logic SELECTCODE = 1'b0,
    parameter int   DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REGSIZE-1:0]     reg_data,
    input  logic [1:0]             S,
    input  logic                   writeSelect,
    input  logic                   sync_clr,
    output logic [REGSIZE-1:0]     m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   misalign_err,
    output logic [7:0]             ovf_cnt
);

    localparam int            CW    = $clog2(REGSIZE);
    localparam logic [CW:0]   FRAME = (CW+1)'(REGSIZE);

    logic [CW-1:0] cnt_p0;
    logic [2:0]    step_p0;
    logic [CW:0]   sum_p0;
    logic          shift_p0;
    logic          wrap_p0;
    logic          over_p0;
    logic          vld_p1;
    logic          pop;
    logic          accept;
    logic          full;
    logic          empty;

    assign step_p0  = mode_step(S);
    assign shift_p0 = (writeSelect == SELECTCODE) && (step_p0 != 3'd0);
    assign sum_p0   = {1'b0, cnt_p0} + (CW+1)'(step_p0);
    assign wrap_p0  = (sum_p0 >= FRAME);
    assign over_p0  = (sum_p0 > FRAME);

    // Stage p0 -> p1: bit count and capture arm; the upstream register settles on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0       <= '0;
            vld_p1       <= 1'b0;
            misalign_err <= 1'b0;
        end else if (sync_clr) begin
            cnt_p0 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= shift_p0 && wrap_p0;
            if (shift_p0) cnt_p0 <= wrap_p0 ? CW'(sum_p0 - FRAME) : sum_p0[CW-1:0];
            if (shift_p0 && over_p0) misalign_err <= 1'b1;
        end
    end

    // Stage p1: frame capture into the FIFO; a clear on this edge cancels it.
    assign pop     = m_valid && m_ready;
    assign accept  = vld_p1 && !sync_clr && (!full || pop);
    assign m_valid = !empty;

    spi_frame_fifo #(
        .WIDTH (REGSIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .din   (reg_data),
        .pop   (pop),
        .dout  (m_data),
        .full  (full),
        .empty (empty),
        .level (level)
    );

`ifdef SPI_FRAME_OVF_CNT_EN
    logic drop;
    assign drop = vld_p1 && !sync_clr && !accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       ovf_cnt <= 8'd0;
        else if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
    end
`else
    assign ovf_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_spi_frame_collector.sv
// Directed bench for spi_frame_collector; models the upstream MSB-first shift register.
module tb_spi_frame_collector;

    localparam int REGSIZE = 8;
    localparam int DEPTH   = 4;
`ifdef SPI_FRAME_OVF_CNT_EN
    localparam int OVF_EXP = 2;
`else
    localparam int OVF_EXP = 0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [REGSIZE-1:0]     reg_data;
    logic [1:0]             S;
    logic                   write_select;
    logic                   sync_clr;
    logic [REGSIZE-1:0]     m_data;
    logic                   m_valid;
    logic                   m_ready;
    logic [$clog2(DEPTH):0] level;
    logic                   misalign_err;
    logic [7:0]             ovf_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_frame_collector #(
        .REGSIZE    (REGSIZE),
        .SELECTCODE (1'b0),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg_data     (reg_data),
        .S            (S),
        .writeSelect  (write_select),
        .sync_clr     (sync_clr),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .level        (level),
        .misalign_err (misalign_err),
        .ovf_cnt      (ovf_cnt)
    );

    typedef struct {
        logic [1:0]  mode;
        int          n;
        logic [31:0] vals;   // k-th lane value in vals[4k +: 4]
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // One shift cycle; the upstream register takes the new lanes at the same edge.
    task automatic shift(input logic [1:0] mode, input logic [3:0] v);
        int w;
        S = mode;
        write_select = 1'b0;
        tick();
        w = (mode == 2'b00) ? 1 : (mode == 2'b01) ? 2 : 4;
        reg_data = (reg_data << w) | {4'b0000, v};
        write_select = 1'b1;
        S = 2'b10;
    endtask

    task automatic pop_one();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{mode: 2'b00, n: 8, vals: 32'h01001101, exp: 8'hB2};
        vecs[1] = '{mode: 2'b11, n: 2, vals: 32'h0000005A, exp: 8'hA5};
        vecs[2] = '{mode: 2'b01, n: 4, vals: 32'h00002103, exp: 8'hC6};
        vecs[3] = '{mode: 2'b00, n: 8, vals: 32'h01111110, exp: 8'h7E};
        vecs[4] = '{mode: 2'b01, n: 4, vals: 32'h00000330, exp: 8'h3C};
        vecs[5] = '{mode: 2'b11, n: 2, vals: 32'h0000000F, exp: 8'hF0};

        rst_n = 1'b0; reg_data = '0; S = 2'b10; write_select = 1'b1;
        sync_clr = 1'b0; m_ready = 1'b0;
        #12;
        check("rst_m_valid", m_valid, 0);
        check("rst_level", level, 0);
        check("rst_misalign", misalign_err, 0);
        check("rst_ovf", ovf_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Table-driven single frames
        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) shift(vecs[i].mode, vecs[i].vals[4*k +: 4]);
            check($sformatf("v%0d_latency", i), m_valid, 0);
            tick();
            check($sformatf("v%0d_valid", i), m_valid, 1);
            check($sformatf("v%0d_data", i), m_data, vecs[i].exp);
            check($sformatf("v%0d_level", i), level, 1);
            check($sformatf("v%0d_misalign", i), misalign_err, 0);
            tick();
            check($sformatf("v%0d_hold", i), m_data, vecs[i].exp);
            pop_one();
            check($sformatf("v%0d_popped", i), level, 0);
        end

        // Misaligned frame: 5 + 4 bits leaves 1 residual bit
        for (int k = 0; k < 5; k++) shift(2'b00, 4'd1);
        shift(2'b11, 4'h0);
        check("mis_flag", misalign_err, 1);
        tick();
        check("mis_level", level, 1);
        check("mis_data", m_data, 8'hF0);
        pop_one();
        for (int k = 0; k < 6; k++) shift(2'b00, 4'd1);
        idle(2);
        check("mis_residual_no_frame", level, 0);
        shift(2'b00, 4'd1);
        tick();
        check("mis_residual_frame", level, 1);
        check("mis_residual_data", m_data, 8'h7F);
        check("mis_sticky", misalign_err, 1);
        pop_one();

        // Reset mid-frame
        for (int k = 0; k < 3; k++) shift(2'b00, 4'd1);
        rst_n = 1'b0;
        #3;
        check("rstmid_misalign", misalign_err, 0);
        check("rstmid_level", level, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 5; k++) shift(2'b00, 4'd0);
        idle(2);
        check("rstmid_partial_dropped", level, 0);
        for (int k = 0; k < 3; k++) shift(2'b00, 4'd1);
        tick();
        check("rstmid_frame", level, 1);
        check("rstmid_data", m_data, 8'h07);
        pop_one();

        // sync_clr between frames
        for (int k = 0; k < 3; k++) shift(2'b00, 4'd1);
        sync_clr = 1'b1; tick(); sync_clr = 1'b0;
        for (int k = 0; k < 8; k++) shift(2'b00, 4'(k % 2));
        tick();
        check("clr_level", level, 1);
        check("clr_data", m_data, 8'h55);
        idle(2);
        check("clr_one_frame", level, 1);
        pop_one();

        // sync_clr cancels an armed capture
        for (int k = 0; k < 8; k++) shift(2'b00, 4'd1);
        sync_clr = 1'b1; tick(); sync_clr = 1'b0;
        idle(1);
        check("clr_cancel_arm", level, 0);

        // sync_clr wins over a coincident completing shift
        for (int k = 0; k < 7; k++) shift(2'b00, 4'd0);
        sync_clr = 1'b1; shift(2'b00, 4'd0); sync_clr = 1'b0;
        idle(2);
        check("clr_wins", level, 0);
        check("clr_wins_misalign", misalign_err, 0);

        // Overflow: six frames into a depth-4 FIFO
        for (int f = 1; f <= 6; f++) begin
            shift(2'b11, 4'(f));
            shift(2'b11, 4'(f));
        end
        idle(1);
        check("ovf_level", level, 4);
        check("ovf_cnt", ovf_cnt, OVF_EXP);
        for (int f = 1; f <= 4; f++) begin
            check($sformatf("ovf_order%0d", f), m_data, {4'(f), 4'(f)});
            pop_one();
        end
        check("ovf_drained", level, 0);
        check("ovf_drained_valid", m_valid, 0);

        // Push and pop on the same edge while full
        for (int f = 1; f <= 4; f++) begin
            shift(2'b11, 4'hA);
            shift(2'b11, 4'(f));
        end
        idle(1);
        check("full_level", level, 4);
        shift(2'b11, 4'hB);
        shift(2'b11, 4'h5);
        check("full_head", m_data, 8'hA1);
        pop_one();
        check("full_pushpop_level", level, 4);
        check("full_pushpop_ovf", ovf_cnt, OVF_EXP);
        check("full_order1", m_data, 8'hA2); pop_one();
        check("full_order2", m_data, 8'hA3); pop_one();
        check("full_order3", m_data, 8'hA4); pop_one();
        check("full_order4", m_data, 8'hB5); pop_one();
        check("full_drained", level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
